// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared widths, saturation limits and output FSM states
package fir_pkg;

    localparam int DEF_DATA_W    = 24;
    localparam int DEF_ACC_W     = 48;
    localparam int DEF_FRAC_BITS = 23;
    localparam int DEF_DEPTH     = 4;

    localparam logic signed [DEF_DATA_W-1:0] SAT_MAX = {1'b0, {(DEF_DATA_W-1){1'b1}}};
    localparam logic signed [DEF_DATA_W-1:0] SAT_MIN = {1'b1, {(DEF_DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVEN = 2'd1,
        ST_ODD  = 2'd2
    } out_state_t;

endpackage

// File: rtl/fir_requant.sv
// rtl/fir_requant.sv - round-half-up shift and saturate of one accumulator sum
module fir_requant
    import fir_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ACC_W     = DEF_ACC_W,
    parameter int FRAC_BITS = DEF_FRAC_BITS
) (
    input  logic signed [ACC_W-1:0]  i_sum,
    output logic signed [DATA_W-1:0] o_sample,
    output logic                     o_clip
);

    localparam logic [ACC_W:0] LP_HALF = {{ACC_W{1'b0}}, 1'b1} << (FRAC_BITS - 1);
    localparam logic signed [DATA_W-1:0] LP_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] LP_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    logic signed [ACC_W:0]         w_ext;
    logic signed [ACC_W:0]         w_rnd;
    logic signed [ACC_W:0]         w_shift;
    logic        [ACC_W-DATA_W+1:0] w_hi;

    // One guard bit keeps the rounding add from wrapping at full scale.
    assign w_ext   = {i_sum[ACC_W-1], i_sum};
    assign w_rnd   = w_ext + LP_HALF;
    assign w_shift = w_rnd >>> FRAC_BITS;

    // The result fits only when every bit above the output sign matches it.
    assign w_hi   = w_shift[ACC_W:DATA_W-1];
    assign o_clip = !((&w_hi) || (~|w_hi));

    always_comb begin
        o_sample = w_shift[DATA_W-1:0];
        if (o_clip) begin
            o_sample = w_shift[ACC_W] ? LP_MIN : LP_MAX;
        end
    end

endmodule

// File: rtl/fir_parallel_output_serializer.sv
// rtl/fir_parallel_output_serializer.sv - requantize even/odd pairs, buffer and re-serialize
module fir_parallel_output_serializer
    import fir_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ACC_W     = DEF_ACC_W,
    parameter int FRAC_BITS = DEF_FRAC_BITS,
    parameter int DEPTH     = DEF_DEPTH
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [ACC_W-1:0]     in_sum_even,
    input  logic signed [ACC_W-1:0]     in_sum_odd,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [DATA_W-1:0]    out_data,
    output logic                        out_phase,
    output logic                        sat_flag,
    input  logic                        sat_clear,
    output logic [$clog2(DEPTH):0]      fifo_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic signed [DATA_W-1:0] w_q_even;
    logic signed [DATA_W-1:0] w_q_odd;
    logic                     w_clip_even;
    logic                     w_clip_odd;

    logic [DATA_W-1:0] r_mem_even [DEPTH];
    logic [DATA_W-1:0] r_mem_odd  [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [LW-1:0]     r_level;
    logic [LW-1:0]     w_level_nxt;
    logic              r_in_ready;

    out_state_t        r_state;
    out_state_t        w_state_nxt;
    logic              w_push;
    logic              w_pop;
    logic              w_ld_odd;
    logic              w_go_idle;

    logic signed [DATA_W-1:0] r_out_data;
    logic signed [DATA_W-1:0] r_hold_odd;
    logic                     r_out_phase;
    logic                     r_out_valid;
    logic                     r_sat;

    fir_requant #(
        .DATA_W    (DATA_W),
        .ACC_W     (ACC_W),
        .FRAC_BITS (FRAC_BITS)
    ) u_requant_even (
        .i_sum    (in_sum_even),
        .o_sample (w_q_even),
        .o_clip   (w_clip_even)
    );

    fir_requant #(
        .DATA_W    (DATA_W),
        .ACC_W     (ACC_W),
        .FRAC_BITS (FRAC_BITS)
    ) u_requant_odd (
        .i_sum    (in_sum_odd),
        .o_sample (w_q_odd),
        .o_clip   (w_clip_odd)
    );

    // in_ready is registered from the next level, so out_ready never reaches it combinationally.
    assign w_push      = in_valid && r_in_ready;
    assign w_level_nxt = r_level + LW'(w_push) - LW'(w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_even[r_wr_ptr] <= w_q_even;
            r_mem_odd[r_wr_ptr]  <= w_q_odd;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_in_ready <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_level    <= w_level_nxt;
            r_in_ready <= (w_level_nxt < LW'(DEPTH));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_ld_odd    = 1'b0;
        w_go_idle   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_level != '0) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_EVEN;
                end
            end
            ST_EVEN: begin
                if (out_ready) begin
                    w_ld_odd    = 1'b1;
                    w_state_nxt = ST_ODD;
                end
            end
            ST_ODD: begin
                if (out_ready) begin
                    if (r_level != '0) begin
                        w_pop       = 1'b1;
                        w_state_nxt = ST_EVEN;
                    end else begin
                        w_go_idle   = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // A pop presents the even sample at once and parks the odd one for the next beat.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out_data  <= '0;
            r_hold_odd  <= '0;
            r_out_phase <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (w_pop) begin
            r_out_data  <= r_mem_even[r_rd_ptr];
            r_hold_odd  <= r_mem_odd[r_rd_ptr];
            r_out_phase <= 1'b0;
            r_out_valid <= 1'b1;
        end else if (w_ld_odd) begin
            r_out_data  <= r_hold_odd;
            r_out_phase <= 1'b1;
        end else if (w_go_idle) begin
            r_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sat <= 1'b0;
        end else if (w_push && (w_clip_even || w_clip_odd)) begin
            r_sat <= 1'b1;
        end else if (sat_clear) begin
            r_sat <= 1'b0;
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_phase  = r_out_phase;
    assign sat_flag   = r_sat;
    assign fifo_level = r_level;

endmodule

// File: tb/tb_fir_parallel_output_serializer.sv
// tb/tb_fir_parallel_output_serializer.sv - scoreboard bench for the output serializer
module tb_fir_parallel_output_serializer;

    typedef struct {
        int data;
        bit phase;
    } exp_t;

    logic               clk = 1'b0;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic signed [47:0] in_sum_even;
    logic signed [47:0] in_sum_odd;
    logic               out_valid;
    logic               out_ready;
    logic signed [23:0] out_data;
    logic               out_phase;
    logic               sat_flag;
    logic               sat_clear;
    logic [2:0]         fifo_level;

    exp_t q_exp[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    fir_parallel_output_serializer dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_sum_even (in_sum_even),
        .in_sum_odd  (in_sum_odd),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_phase   (out_phase),
        .sat_flag    (sat_flag),
        .sat_clear   (sat_clear),
        .fifo_level  (fifo_level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Inputs change 1 time unit after a rising edge; the monitor samples on the falling edge.
    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            if (q_exp.size() == 0) begin
                chk("unexpected_sample", longint'(out_data), 0);
            end else begin
                exp_t e;
                e = q_exp.pop_front();
                chk("sample_data", longint'(out_data), longint'(e.data));
                chk("sample_phase", longint'(out_phase), longint'(e.phase));
            end
        end
    end

    task automatic push_pair(input longint se, input longint so, input int ee, input int eo);
        int   n;
        exp_t e;
        in_sum_even = se[47:0];
        in_sum_odd  = so[47:0];
        in_valid    = 1'b1;
        n = 0;
        while (!in_ready && n < 200) begin
            step();
            n++;
        end
        if (!in_ready) begin
            chk("push_timeout", 1, 0);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            e.data = ee; e.phase = 1'b0; q_exp.push_back(e);
            e.data = eo; e.phase = 1'b1; q_exp.push_back(e);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q_exp.size() != 0 || out_valid) && n < 200) begin
            step();
            n++;
        end
        chk("drain_pending", longint'(q_exp.size()), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b0;
        in_valid    = 1'b1;
        in_sum_even = '0;
        in_sum_odd  = '0;
        out_ready   = 1'b1;
        sat_clear   = 1'b0;
        repeat (3) step();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_fifo_level", fifo_level, 0);
        in_valid = 1'b0;
        reset    = 1'b1;
        step();
        step();
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_level", fifo_level, 0);
        chk("post_rst_sat", sat_flag, 0);

        // Single pair with latency checks.
        push_pair(64'sd5 <<< 23, -(64'sd3 <<< 23), 5, -3);
        chk("lat_k_valid", out_valid, 0);
        step();
        chk("lat_k1_valid", out_valid, 1);
        chk("lat_k1_data", out_data, 5);
        chk("lat_k1_phase", out_phase, 0);
        step();
        chk("lat_k2_data", out_data, -3);
        chk("lat_k2_phase", out_phase, 1);
        step();
        chk("lat_k3_valid", out_valid, 0);

        // Rounding boundaries around one half LSB.
        push_pair(64'sd4194304, 64'sd4194303, 1, 0);
        push_pair(-64'sd4194304, -64'sd4194305, 0, -1);
        drain();
        chk("round_no_sat", sat_flag, 0);

        // Saturation, clear, and set winning over clear.
        push_pair(64'sh7FFF_FFFF_FFFF, -64'sh8000_0000_0000, 8388607, -8388608);
        drain();
        chk("sat_set", sat_flag, 1);
        sat_clear = 1'b1;
        step();
        sat_clear = 1'b0;
        chk("sat_cleared", sat_flag, 0);
        sat_clear = 1'b1;
        push_pair(64'sh7FFF_FFFF_FFFF, 64'sd0, 8388607, 0);
        sat_clear = 1'b0;
        chk("sat_set_wins", sat_flag, 1);
        drain();

        // Backpressure: five pairs fit, the sixth waits at the input.
        out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            push_pair(longint'(100 + i) <<< 23, -(longint'(100 + i) <<< 23), 100 + i, -(100 + i));
        end
        in_sum_even = 48'sd106 <<< 23;
        in_sum_odd  = -(48'sd106 <<< 23);
        in_valid    = 1'b1;
        repeat (4) step();
        chk("bp_in_ready", in_ready, 0);
        chk("bp_level", fifo_level, 4);
        chk("bp_hold_valid", out_valid, 1);
        chk("bp_hold_data", out_data, 101);
        chk("bp_hold_phase", out_phase, 0);
        out_ready = 1'b1;
        push_pair(64'sd106 <<< 23, -(64'sd106 <<< 23), 106, -106);
        drain();

        // Back-to-back pairs: the output must not bubble between pairs.
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    push_pair(longint'(20 + i) <<< 23,
                              (longint'(30 + i) <<< 23) + 64'sd4194304, 20 + i, 31 + i);
                end
            end
            begin
                int n;
                int gaps;
                int bad_phase;
                n = 0; gaps = 0; bad_phase = 0;
                @(negedge clk);
                while (!out_valid && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                chk("b2b_start", out_valid, 1);
                for (int i = 0; i < 8; i++) begin
                    if (!out_valid) gaps++;
                    if (out_phase != i[0]) bad_phase++;
                    @(negedge clk);
                end
                chk("b2b_gaps", gaps, 0);
                chk("b2b_phase_alt", bad_phase, 0);
            end
        join
        drain();
        chk("end_level", fifo_level, 0);
        chk("end_valid", out_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fir_parallel_output_serializer.md
Name: fir_parallel_output_serializer

Overview:
Downstream stage of the L=2 parallel FIR filter. Accepts each even/odd pair of 48-bit accumulator sums from the filter core and requantizes each sum to 24 bits with rounding and saturation. Buffers the pairs in a small FIFO and re-serializes them into one full-rate 24-bit stream with a valid/ready handshake, in order even then odd. Feeds the DAC/output interface and restores the original sample order.

Parameters:
DATA_W, 24, output sample width (signed)
ACC_W, 48, input accumulator width (signed)
FRAC_BITS, 23, right shift applied to sums (Q1.23 coefficients)
DEPTH, 4, pair-FIFO depth in pairs (power of 2, >=2)

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
in_valid  in  1  pair present on in_sum_even/in_sum_odd
in_ready  out  1  block can accept a pair
in_sum_even  in  ACC_W  signed even-phase accumulator sum
in_sum_odd  in  ACC_W  signed odd-phase accumulator sum
out_valid  out  1  out_data holds a valid sample
out_ready  in  1  consumer accepts out_data
out_data  out  DATA_W  signed serialized sample
out_phase  out  1  0 = even sample, 1 = odd sample
sat_flag  out  1  sticky: a sample was clipped
sat_clear  in  1  synchronous clear of sat_flag
fifo_level  out  $clog2(DEPTH)+1  pairs stored in FIFO (holding register excluded)

Behaviour:
- Reset is asynchronous and active-low, on port reset, single clock clk. While reset=0: out_valid=0, out_data=0, out_phase=0, sat_flag=0, fifo_level=0, FIFO pointers=0, state=IDLE, in_ready=0.
- After reset release: in_ready = (fifo_level < DEPTH). No combinational path from out_ready to in_ready. A full FIFO refuses a push even if a pop happens in the same cycle.
- Accept: in_valid && in_ready on a rising edge. Both sums are requantized and written as one 2x24-bit entry.
- Requantization, applied per sum s: t = (s + 2^(FRAC_BITS-1)) >>> FRAC_BITS, arithmetic shift, computed at ACC_W+1 bits so the add cannot overflow. This is round-half-up. Saturate t to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- sat_flag sets on any accepted clip. sat_clear clears it. If set and clear occur in the same cycle, set wins.
- Output FSM (out_data and out_phase are registered; holding register keeps the current pair):
  IDLE: out_valid=0. If fifo_level>0: pop head into holding, out_data=even, out_phase=0, out_valid=1, go to EVEN.
  EVEN: if out_ready: out_data=odd, out_phase=1, go to ODD. Otherwise hold all outputs.
  ODD: if out_ready and fifo_level>0: pop next pair, present its even sample, go to EVEN (no bubble). If out_ready and FIFO empty: out_valid=0, go to IDLE. Otherwise hold.
- Latency: a pair accepted at edge k into an empty block gives out_valid=1 with its even sample after edge k+1.
- Throughput: 1 sample/cycle out; sustained 1 pair per 2 cycles in. Total capacity is DEPTH+1 pairs.
- Push and pop in the same cycle: fifo_level unchanged, pointers wrap modulo DEPTH.
- out_data/out_phase never change while out_valid=1 and out_ready=0.
- Reset mid-operation: all in-flight pairs are discarded. No partial pair is emitted after release.

Decomposition:
- Package fir_pkg: DATA_W, ACC_W, FRAC_BITS defaults, SAT_MAX/SAT_MIN constants, output-FSM state encoding (IDLE/EVEN/ODD).
- One sub-module: fir_requant, a combinational round-and-saturate that outputs the sample plus a clip bit. It is instantiated twice, once for the even sum and once for the odd sum.

Test Plan:
- Reset: hold reset=0 with in_valid=1 -> out_valid=0, in_ready=0. After release: in_ready=1, fifo_level=0, sat_flag=0.
- Single pair, out_ready=1: sums 5*2^23 and -3*2^23 -> 5 (phase 0) after edge k+1, -3 (phase 1) on the next cycle, then out_valid=0.
- Rounding:
  - 2^22 -> 1
  - 2^22-1 -> 0
  - -2^22 -> 0
  - -2^22-1 -> -1
  - none of these set sat_flag.
- Saturation: 2^47-1 -> 8388607 and -2^47 -> -8388608, sat_flag=1. Pulse sat_clear -> 0. A clip coinciding with sat_clear -> sat_flag=1.
- Backpressure: out_ready=0, push 6 distinct pairs -> 5 accepted, in_ready=0 from then on, 6th held at input. Then out_ready=1 -> all 12 samples in order, no loss, no duplicates.
- Back-to-back: continuous pairs with out_ready=1 -> out_valid stays 1 with no bubble between pairs, and phase alternates 0,1,0,1.
